// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-outstanding request/response controller in front of a
// simple data_mem. A request is captured in IDLE. An in-range address is
// driven to data_mem for one ISSUE cycle. Reads then wait READ_LAT cycles
// and capture mem_data. Every request ends in RESP, which holds the response
// until the consumer takes it. Out-of-range addresses skip memory entirely
// and respond at once with resp_err.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     request handshake; req_write, req_addr, req_wdata payload
//   resp_valid/ready    response handshake; resp_rdata, resp_err payload
//   mem_pointer         data_mem address (holds outside ISSUE)
//   mem_write_data      one-cycle write strobe
//   mem_read_data       one-cycle read strobe
//   mem_data_to_write   data_mem write data (holds outside ISSUE)
//   mem_data            data_mem read data
//   busy                controller not idle
//   wr_count, rd_count  completed non-error writes / reads, wrapping 8-bit
module data_mem_ctrl #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 3,
  parameter int MEM_DEPTH = 6,
  parameter int READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_pointer,
  output logic              mem_write_data,
  output logic              mem_read_data,
  output logic [DATA_W-1:0] mem_data_to_write,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic [7:0]        wr_count,
  output logic [7:0]        rd_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [2:0]      WAIT_LOAD = 3'(READ_LAT - 1);

  state_t      state;
  state_t      state_nx;
  logic        req_write_q;
  logic [2:0]  wait_cnt;
  logic        req_fire;
  logic        addr_bad;

  assign req_ready = (state == IDLE) && !reset;
  assign req_fire  = req_valid && req_ready;
  assign addr_bad  = {1'b0, req_addr} >= DEPTH_LIM;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and state-decoded outputs. The strobes come straight from the
  // state, so they are low in the cycle after any reset edge.
  always_comb begin
    state_nx       = state;
    mem_write_data = 1'b0;
    mem_read_data  = 1'b0;
    resp_valid     = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        if (req_fire) begin
          state_nx = addr_bad ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_write_data = req_write_q;
        mem_read_data  = !req_write_q;
        state_nx       = req_write_q ? RESP : WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath. mem_pointer and mem_data_to_write double as the registered
  // address and write data. They load only for in-range requests, so an
  // error request leaves the memory-side outputs untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_write_q       <= 1'b0;
      wait_cnt          <= '0;
      resp_rdata        <= '0;
      resp_err          <= 1'b0;
      mem_pointer       <= '0;
      mem_data_to_write <= '0;
      wr_count          <= '0;
      rd_count          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            req_write_q <= req_write;
            resp_err    <= addr_bad;
            resp_rdata  <= '0;
            if (!addr_bad) begin
              mem_pointer <= req_addr;
              if (req_write) begin
                mem_data_to_write <= req_wdata;
              end
            end
          end
        end
        ISSUE: begin
          wait_cnt <= WAIT_LOAD;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            resp_rdata <= mem_data;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          if (resp_ready && !resp_err) begin
            if (req_write_q) begin
              wr_count <= wr_count + 8'd1;
            end else begin
              rd_count <= rd_count + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed vector table, randomized
// transactions against a behavioural model, and multi-cycle sequences for
// request spacing, reset abort and counter wrap.
module tb_data_mem_ctrl;

  localparam int DATA_W    = 256;
  localparam int ADDR_W    = 3;
  localparam int MEM_DEPTH = 6;
  localparam int READ_LAT  = 1;
  localparam int NLOC      = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] JUNK = {8{32'hDEAD_BEEF}};

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_pointer;
  logic              mem_write_data;
  logic              mem_read_data;
  logic [DATA_W-1:0] mem_data_to_write;
  logic [DATA_W-1:0] mem_data;
  logic              busy;
  logic [7:0]        wr_count;
  logic [7:0]        rd_count;

  data_mem_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_pointer      (mem_pointer),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .mem_data_to_write(mem_data_to_write),
    .mem_data         (mem_data),
    .busy             (busy),
    .wr_count         (wr_count),
    .rd_count         (rd_count)
  );

  always #5 clk = ~clk;

  // data_mem stand-in: read data is valid only in the last cycle before the
  // capture edge, so early or late capture picks up JUNK.
  logic [DATA_W-1:0] mem [0:NLOC-1];
  logic [ADDR_W-1:0] rd_addr;
  int unsigned       pend;

  always @(posedge clk) begin
    if (mem_write_data) mem[mem_pointer] <= mem_data_to_write;
    if (mem_read_data) begin
      pend    <= READ_LAT;
      rd_addr <= mem_pointer;
    end else if (pend != 0) begin
      pend <= pend - 1;
    end
  end

  assign mem_data = (pend == 1) ? mem[rd_addr] : JUNK;

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [0:NLOC-1];
  logic [7:0]        m_wc;
  logic [7:0]        m_rc;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rep(input logic [31:0] w);
    return {8{w}};
  endfunction

  function automatic logic [DATA_W-1:0] rnd256();
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[DATA_W-33:0], 32'($urandom)};
    return r;
  endfunction

  // One full transaction, starting and ending just after a falling edge.
  task automatic do_txn(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input int unsigned hold,
                        input logic exp_err, input logic [DATA_W-1:0] exp_rdata,
                        input int unsigned exp_lat);
    int unsigned       k;
    int unsigned       n_ws;
    int unsigned       n_rs;
    logic              seen;
    logic [ADDR_W-1:0] ptr_s;
    logic [DATA_W-1:0] wd_s;
    logic              mem_txn;

    mem_txn = !exp_err;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_idle", 32'(req_ready), 1);

    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    // Payload changes after acceptance must be ignored.
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = ADDR_W'($urandom);
    req_wdata = rnd256();

    n_ws = 0;
    n_rs = 0;
    k = 0;
    seen = 1'b0;
    ptr_s = '0;
    wd_s = '0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (mem_write_data) begin
        n_ws++;
        ptr_s = mem_pointer;
        wd_s  = mem_data_to_write;
      end
      if (mem_read_data) begin
        n_rs++;
        ptr_s = mem_pointer;
      end
      if (resp_valid) seen = 1'b1;
    end

    chk("resp_latency", k, exp_lat);
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    chkw("resp_rdata", resp_rdata, exp_rdata);
    chk("wr_strobes", n_ws, (mem_txn && wr) ? 1 : 0);
    chk("rd_strobes", n_rs, (mem_txn && !wr) ? 1 : 0);
    if (mem_txn) chk("strobe_pointer", 32'(ptr_s), 32'(addr));
    if (mem_txn && wr) chkw("strobe_wdata", wd_s, wd);

    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      chk("hold_resp_valid", 32'(resp_valid), 1);
      chkw("hold_resp_rdata", resp_rdata, exp_rdata);
      chk("hold_resp_err", 32'(resp_err), 32'(exp_err));
      chk("hold_req_ready", 32'(req_ready), 0);
    end

    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    if (mem_txn && wr) begin
      m_wc = m_wc + 8'd1;
      ref_mem[addr] = wd;
    end
    if (mem_txn && !wr) m_rc = m_rc + 8'd1;

    chk("done_resp_valid", 32'(resp_valid), 0);
    chk("done_busy", 32'(busy), 0);
    chk("wr_count", 32'(wr_count), 32'(m_wc));
    chk("rd_count", 32'(rd_count), 32'(m_rc));
  endtask

  // Back-to-back requests with resp_ready held high; checks the gap in
  // cycles between successive acceptances.
  task automatic spacing(input logic wr, input int unsigned exp_gap);
    int unsigned       last;
    int unsigned       n_acc;
    int unsigned       k;
    logic [DATA_W-1:0] d;

    d = rep(32'h5A5A_C3C3);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = 3'd4;
    req_wdata  = d;
    last  = 0;
    n_acc = 0;
    for (int c = 0; c < 40 && n_acc < 3; c++) begin
      if (req_ready) begin
        if (n_acc > 0) chk("req_spacing", c - last, exp_gap);
        last = c;
        n_acc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("spacing_accepts", n_acc, 3);

    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    resp_ready = 1'b0;
    chk("spacing_drained", 32'(busy), 0);
    if (wr) begin
      m_wc = m_wc + 8'(n_acc);
      ref_mem[4] = d;
    end else begin
      m_rc = m_rc + 8'(n_acc);
    end
    chk("spacing_wr_count", 32'(wr_count), 32'(m_wc));
    chk("spacing_rd_count", 32'(rd_count), 32'(m_rc));
  endtask

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int unsigned       hold;
    logic              exp_err;
    logic [DATA_W-1:0] exp_rdata;
    int unsigned       exp_lat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic wr, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] wd, input int unsigned hold,
                     input logic e, input logic [DATA_W-1:0] rd, input int unsigned lat);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wd; v.hold = hold;
    v.exp_err = e; v.exp_rdata = rd; v.exp_lat = lat;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] exp;
    int unsigned       last_i;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic              e;

    // Directed vectors: wr, addr, wdata, hold, exp_err, exp_rdata, exp_lat.
    add(1, 3'd0, rep(32'h1111_0000),   0, 0, '0, 2);
    add(1, 3'd1, rep(32'h2222_0001),   0, 0, '0, 2);
    add(1, 3'd2, {64{4'h5}},           0, 0, '0, 2);
    add(1, 3'd3, rep(32'h3333_0003),   0, 0, '0, 2);
    add(1, 3'd4, rep(32'h4444_0004),   1, 0, '0, 2);
    add(1, 3'd5, rep(32'h5555_AAAA),   0, 0, '0, 2);
    add(1, 3'd2, {64{4'hA}},           0, 0, '0, 2);
    add(0, 3'd2, '0,                   0, 0, {64{4'hA}}, 3);
    add(0, 3'd6, '0,                   0, 1, '0, 1);
    add(0, 3'd7, '0,                   2, 1, '0, 1);
    add(1, 3'd6, rep(32'hBAD0_BAD0),   0, 1, '0, 1);
    add(0, 3'd5, '0,                   5, 0, rep(32'h5555_AAAA), 3);
    add(0, 3'd0, '0,                   2, 0, rep(32'h1111_0000), 3);
    add(1, 3'd5, '1,                   3, 0, '0, 2);
    add(0, 3'd5, '0,                   0, 0, '1, 3);
    add(0, 3'd3, '0,                   1, 0, rep(32'h3333_0003), 3);

    for (int i = 0; i < NLOC; i++) ref_mem[i] = '0;
    m_wc = '0;
    m_rc = '0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    resp_ready = 1'b0;
    reset = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_strobe", 32'(mem_write_data), 0);
    chk("rst_rd_strobe", 32'(mem_read_data), 0);
    chk("rst_mem_pointer", 32'(mem_pointer), 0);
    chkw("rst_resp_rdata", resp_rdata, '0);
    chkw("rst_mem_wdata", mem_data_to_write, '0);
    chk("rst_wr_count", 32'(wr_count), 0);
    chk("rst_rd_count", 32'(rd_count), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 1);

    foreach (tbl[i]) begin
      do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
             tbl[i].exp_err, tbl[i].exp_rdata, tbl[i].exp_lat);
    end

    spacing(1'b1, 3);
    spacing(1'b0, 3 + READ_LAT);

    // Randomized transactions against the model.
    for (int n = 0; n < 80; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = ADDR_W'($urandom_range(0, NLOC - 1));
      e    = (int'(addr) >= MEM_DEPTH);
      exp  = (e || wr) ? '0 : ref_mem[addr];
      do_txn(wr, addr, rnd256(), $urandom_range(0, 3), e, exp,
             e ? 1 : (wr ? 2 : 2 + READ_LAT));
    end

    // Reset while a read sits in WAIT.
    chk("abort_req_ready", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 3'd1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_issue_strobe", 32'(mem_read_data), 1);
    @(negedge clk);
    chk("abort_wait_busy", 32'(busy), 1);
    chk("abort_wait_resp_valid", 32'(resp_valid), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_resp_valid", 32'(resp_valid), 0);
    chk("abort_wr_strobe", 32'(mem_write_data), 0);
    chk("abort_rd_strobe", 32'(mem_read_data), 0);
    chk("abort_rd_count", 32'(rd_count), 0);
    chk("abort_wr_count", 32'(wr_count), 0);
    chk("abort_mem_pointer", 32'(mem_pointer), 0);
    reset = 1'b0;
    m_wc = '0;
    m_rc = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_late_resp", 32'(resp_valid), 0);
    chk("abort_rd_count_held", 32'(rd_count), 0);
    resp_ready = 1'b0;

    // 257 writes: walking 0xAA byte across locations 0-5, counter wraps.
    base = '0;
    base[7:0] = 8'hAA;
    for (int i = 0; i < 257; i++) begin
      do_txn(1'b1, ADDR_W'(i % MEM_DEPTH), base << (8 * (i % 32)), 0, 1'b0, '0, 2);
      if (i == 255) chk("wr_count_wrap", 32'(wr_count), 0);
    end
    chk("wr_count_after_wrap", 32'(wr_count), 1);
    for (int a = 0; a < MEM_DEPTH; a++) begin
      last_i = 0;
      for (int i = 0; i < 257; i++) if (i % MEM_DEPTH == a) last_i = i;
      do_txn(1'b0, ADDR_W'(a), '0, 0, 1'b0, base << (8 * (last_i % 32)), 2 + READ_LAT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
